// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared MMU/SRAM widths, burst length and arbiter state encoding
package mmu_pkg;

  localparam int DATA_BIT       = 8;
  localparam int LOGIC_ADDR_BIT = 3;
  localparam int FRAME_BIT      = 2;
  localparam int SRAM_PACK_BIT  = 3;
  localparam int BURST_LEN      = 1 << SRAM_PACK_BIT;
  localparam int PIPE_LAT       = 2;
  localparam int GAP_CYCLES     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } mmu_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting after the last winner
module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_BIT   = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_BIT-1:0]   last,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IDX_BIT-1:0]   idx,
  output logic                 valid
);

  int               sum;
  logic [IDX_BIT-1:0] pos;

  // Walk ports last+1, last+2, ... (wrapping) and take the first requester.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    sum   = 0;
    pos   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      sum = int'(last) + k;
      if (sum >= NUM_PORTS) begin
        sum = sum - NUM_PORTS;
      end
      pos = IDX_BIT'(sum);
      if (!valid && req[pos]) begin
        valid    = 1'b1;
        idx      = pos;
        gnt[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - round-robin block-transaction scheduler for the shared packet SRAM
module sram_port_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int DATA_BIT       = mmu_pkg::DATA_BIT,
  parameter int LOGIC_ADDR_BIT = mmu_pkg::LOGIC_ADDR_BIT,
  parameter int FRAME_BIT      = mmu_pkg::FRAME_BIT,
  parameter int BURST_LEN      = mmu_pkg::BURST_LEN,
  parameter int PIPE_LAT       = mmu_pkg::PIPE_LAT,
  parameter int GAP_CYCLES     = mmu_pkg::GAP_CYCLES
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_PORTS-1:0]              req,
  input  logic [NUM_PORTS-1:0]              req_rw,
  input  logic [NUM_PORTS*LOGIC_ADDR_BIT-1:0] req_addr,
  input  logic [NUM_PORTS*FRAME_BIT-1:0]    req_frame,
  input  logic [NUM_PORTS*DATA_BIT-1:0]     req_wdata,
  output logic [NUM_PORTS-1:0]              gnt,
  output logic                              wr_beat,
  output logic                              rd_valid,
  output logic [DATA_BIT-1:0]               rd_data,
  output logic                              done,
  output logic                              busy,
  output logic                              mmu_start,
  output logic                              mmu_rw_ena,
  output logic [LOGIC_ADDR_BIT-1:0]         mmu_addr,
  output logic [FRAME_BIT-1:0]              mmu_frame,
  output logic [DATA_BIT-1:0]               mmu_wdata,
  input  logic [DATA_BIT-1:0]               mmu_rdata
);

  import mmu_pkg::*;

  localparam int XFER_LEN = BURST_LEN + PIPE_LAT;
  localparam int CNT_BIT  = $clog2(XFER_LEN + 1);
  localparam int GAP_BIT  = $clog2(GAP_CYCLES + 1);
  localparam int IDX_BIT  = $clog2(NUM_PORTS);

  localparam logic [CNT_BIT-1:0] CNT_LAST   = CNT_BIT'(XFER_LEN - 1);
  localparam logic [CNT_BIT-1:0] CNT_WR_END = CNT_BIT'(BURST_LEN);
  localparam logic [CNT_BIT-1:0] CNT_RD_BEG = CNT_BIT'(PIPE_LAT);
  localparam logic [CNT_BIT-1:0] CNT_RD_END = CNT_BIT'(PIPE_LAT + BURST_LEN);
  localparam logic [GAP_BIT-1:0] GAP_LAST   = GAP_BIT'(GAP_CYCLES - 1);

  mmu_state_e                state_q, state_d;
  logic [CNT_BIT-1:0]        cnt_q, cnt_d;
  logic [GAP_BIT-1:0]        gap_q, gap_d;
  logic [IDX_BIT-1:0]        last_q, last_d;
  logic [IDX_BIT-1:0]        idx_q, idx_d;
  logic [NUM_PORTS-1:0]      gsel_q, gsel_d;
  logic                      rw_q, rw_d;
  logic [LOGIC_ADDR_BIT-1:0] addr_q, addr_d;
  logic [FRAME_BIT-1:0]      frame_q, frame_d;

  logic [NUM_PORTS-1:0]      pick_gnt;
  logic [IDX_BIT-1:0]        pick_idx;
  logic                      pick_valid;

  logic                      sel_rw;
  logic [LOGIC_ADDR_BIT-1:0] sel_addr;
  logic [FRAME_BIT-1:0]      sel_frame;
  logic [DATA_BIT-1:0]       wdata_sel;
  logic                      in_xfer;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_BIT   (IDX_BIT)
  ) u_rr (
    .req   (req),
    .last  (last_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Select the arbitration winner's request fields for latching.
  always_comb begin
    sel_rw    = 1'b0;
    sel_addr  = '0;
    sel_frame = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick_idx == IDX_BIT'(i)) begin
        sel_rw    = req_rw[i];
        sel_addr  = req_addr[i*LOGIC_ADDR_BIT +: LOGIC_ADDR_BIT];
        sel_frame = req_frame[i*FRAME_BIT +: FRAME_BIT];
      end
    end
  end

  // Select the granted writer's current data word.
  always_comb begin
    wdata_sel = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (idx_q == IDX_BIT'(i)) begin
        wdata_sel = req_wdata[i*DATA_BIT +: DATA_BIT];
      end
    end
  end

  // State, counters and latched transaction fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      last_q  <= IDX_BIT'(NUM_PORTS - 1);
      idx_q   <= '0;
      gsel_q  <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      gsel_q  <= gsel_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      frame_q <= frame_d;
    end
  end

  // Next state: arbitrate only in IDLE, run the burst, then a fixed idle gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    last_d  = last_q;
    idx_d   = idx_q;
    gsel_d  = gsel_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    frame_d = frame_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        gap_d = '0;
        if (pick_valid) begin
          state_d = XFER;
          idx_d   = pick_idx;
          gsel_d  = pick_gnt;
          last_d  = pick_idx;
          rw_d    = sel_rw;
          addr_d  = sel_addr;
          frame_d = sel_frame;
        end
      end
      XFER: begin
        if (cnt_q == CNT_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
          gap_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        gap_d   = '0;
      end
    endcase
  end

  // Outputs decoded from state, beat counter and latched fields only.
  always_comb begin
    in_xfer    = (state_q == XFER);
    busy       = (state_q != IDLE);
    gnt        = in_xfer ? gsel_q : '0;
    mmu_start  = in_xfer;
    mmu_rw_ena = in_xfer & rw_q;
    mmu_addr   = in_xfer ? addr_q : '0;
    mmu_frame  = in_xfer ? frame_q : '0;
    wr_beat    = in_xfer & ~rw_q & (cnt_q < CNT_WR_END);
    rd_valid   = in_xfer & rw_q & (cnt_q >= CNT_RD_BEG) & (cnt_q < CNT_RD_END);
    done       = in_xfer & (cnt_q == CNT_LAST);
    mmu_wdata  = wr_beat ? wdata_sel : '0;
    rd_data    = rd_valid ? mmu_rdata : '0;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - randomized and directed self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

  localparam int N   = 4;
  localparam int DB  = 8;
  localparam int AB  = 3;
  localparam int FB  = 2;
  localparam int BL  = 8;
  localparam int PL  = 2;
  localparam int GP  = 2;
  localparam int XL  = BL + PL;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, req_rw;
  logic [N*AB-1:0] req_addr;
  logic [N*FB-1:0] req_frame;
  logic [N*DB-1:0] req_wdata;
  logic [N-1:0]    gnt;
  logic            wr_beat, rd_valid, done, busy, mmu_start, mmu_rw_ena;
  logic [DB-1:0]   rd_data, mmu_wdata, mmu_rdata;
  logic [AB-1:0]   mmu_addr;
  logic [FB-1:0]   mmu_frame;

  int n_checks = 0;
  int n_errors = 0;

  int         m_pos, m_port, m_last;
  logic       m_rw;
  logic [AB-1:0] m_addr;
  logic [FB-1:0] m_frame;

  int exp_order[5] = '{0, 1, 2, 3, 0};

  sram_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_frame(req_frame), .req_wdata(req_wdata), .gnt(gnt), .wr_beat(wr_beat),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .busy(busy),
    .mmu_start(mmu_start), .mmu_rw_ena(mmu_rw_ena), .mmu_addr(mmu_addr),
    .mmu_frame(mmu_frame), .mmu_wdata(mmu_wdata), .mmu_rdata(mmu_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (((v >> i) & 1) != 0) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_pos = -1; m_last = N - 1; m_port = 0; m_rw = 1'b0; m_addr = '0; m_frame = '0;
  endtask

  // Transaction-level reference: position within the 1+XL+GP schedule, or -1 when idle.
  task automatic model_step();
    bit found;
    int p;
    found = 0;
    if (m_pos < 0) begin
      for (int k = 1; k <= N; k++) begin
        p = (m_last + k) % N;
        if (!found && ((req >> p) & 1) != 0) begin
          found = 1; m_port = p; m_last = p; m_pos = 0;
          m_rw = ((req_rw >> p) & 1) != 0;
          m_addr = AB'(req_addr >> (p * AB));
          m_frame = FB'(req_frame >> (p * FB));
        end
      end
    end else begin
      m_pos++;
      if (m_pos == XL + GP) m_pos = -1;
    end
  endtask

  task automatic compare_all();
    bit in_x, e_wr, e_rv;
    in_x = (m_pos >= 0) && (m_pos < XL);
    e_wr = in_x && !m_rw && (m_pos < BL);
    e_rv = in_x && m_rw && (m_pos >= PL) && (m_pos < PL + BL);
    check("gnt", 32'(gnt), in_x ? (32'd1 << m_port) : 32'd0);
    check("wr_beat", 32'(wr_beat), 32'(e_wr));
    check("rd_valid", 32'(rd_valid), 32'(e_rv));
    check("rd_data", 32'(rd_data), e_rv ? 32'(mmu_rdata) : 32'd0);
    check("done", 32'(done), 32'(in_x && (m_pos == XL - 1)));
    check("busy", 32'(busy), 32'(m_pos >= 0));
    check("mmu_start", 32'(mmu_start), 32'(in_x));
    check("mmu_rw_ena", 32'(mmu_rw_ena), 32'(in_x && m_rw));
    check("mmu_addr", 32'(mmu_addr), in_x ? 32'(m_addr) : 32'd0);
    check("mmu_frame", 32'(mmu_frame), in_x ? 32'(m_frame) : 32'd0);
    check("mmu_wdata", 32'(mmu_wdata), e_wr ? 32'(DB'(req_wdata >> (m_port * DB))) : 32'd0);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    if (rst_n) model_step();
  endtask

  task automatic chk();
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_inputs();
    req = '0; req_rw = '0; req_addr = '0; req_frame = '0; req_wdata = '0; mmu_rdata = '0;
  endtask

  task automatic set_port(input int p, input logic rw, input logic [AB-1:0] a,
                          input logic [FB-1:0] f, input logic [DB-1:0] d);
    req_rw[p] = rw;
    req_addr[p*AB +: AB] = a;
    req_frame[p*FB +: FB] = f;
    req_wdata[p*DB +: DB] = d;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  initial begin
    int ng, nw, nr, dpos, frv, nd, td, rg;
    int gport[5];
    int gcyc[5];
    logic [N-1:0] prev;
    bit seen;

    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Single write on port 2
    ng = 0; nw = 0; dpos = -1;
    req = 4'b0100;
    set_port(2, 1'b0, 3'd5, 2'd1, 8'h10);
    adv();
    req = '0;
    for (int t = 0; t < XL + GP; t++) begin
      req_wdata[2*DB +: DB] = (m_pos >= 0 && m_pos < BL) ? DB'(8'h10 + m_pos) : 8'h00;
      chk();
      if (gnt == 4'b0100) ng++;
      if (wr_beat) begin
        check("wr_data_seq", 32'(mmu_wdata), 32'(8'h10 + nw));
        nw++;
      end
      if (done) dpos = t;
      adv();
    end
    check("wr_gnt_cycles", 32'(ng), 32'd10);
    check("wr_beat_count", 32'(nw), 32'd8);
    check("wr_done_pos", 32'(dpos), 32'd9);

    // Single read on port 1
    nr = 0; frv = -1;
    set_port(1, 1'b1, 3'd3, 2'd2, 8'h00);
    req = 4'b0010;
    adv();
    req = '0;
    for (int t = 0; t < XL + GP; t++) begin
      mmu_rdata = (m_pos >= PL && m_pos < PL + BL) ? DB'(8'hA0 + m_pos - PL) : DB'($urandom);
      chk();
      if (rd_valid) begin
        if (frv < 0) frv = t;
        check("rd_data_seq", 32'(rd_data), 32'(8'hA0 + nr));
        nr++;
      end
      adv();
    end
    check("rd_valid_count", 32'(nr), 32'd8);
    check("rd_first_pos", 32'(frv), 32'd2);

    // All four ports requesting from reset
    do_reset();
    req = 4'hF;
    ng = 0; prev = '0;
    for (int t = 0; t < 80 && ng < 5; t++) begin
      adv();
      chk();
      if (gnt != 0 && prev == 0) begin
        gport[ng] = oh_idx(gnt); gcyc[ng] = t; ng++;
      end
      prev = gnt;
    end
    check("rr_grant_count", 32'(ng), 32'd5);
    for (int i = 0; i < ng; i++) check("rr_order", 32'(gport[i]), 32'(exp_order[i]));
    for (int i = 1; i < ng; i++) check("rr_period", 32'(gcyc[i] - gcyc[i-1]), 32'd13);

    // Port 0 drops req mid-transaction; port 2 waiting
    do_reset();
    req = 4'b0101;
    ng = 0; nd = 0; prev = '0;
    for (int t = 0; t < 40 && ng < 2; t++) begin
      adv();
      if (ng == 1 && m_pos == 3) req = 4'b0100;
      chk();
      if (done && ng == 1) nd++;
      if (gnt != 0 && prev == 0) begin
        gport[ng] = oh_idx(gnt); ng++;
      end
      prev = gnt;
    end
    check("drop_grants", 32'(ng), 32'd2);
    check("drop_first_port", 32'(gport[0]), 32'd0);
    check("drop_done_count", 32'(nd), 32'd1);
    check("drop_next_port", 32'(gport[1]), 32'd2);

    // Reset pulsed during XFER cycle 5
    do_reset();
    req = 4'b0010;
    for (int t = 0; t < 20; t++) begin
      adv();
      if (m_pos >= 0) req = '0;
      chk();
      if (m_pos == 5) break;
    end
    check("pre_rst_pos", 32'(m_pos), 32'd5);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(mmu_start), 32'd0);
    compare_all();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    req = 4'hF;
    adv();
    chk();
    check("post_rst_winner", 32'(oh_idx(gnt)), 32'd0);

    // Port 3 alone holds req across done
    do_reset();
    req = 4'b1000;
    seen = 0; td = -1; rg = -1; prev = '0;
    for (int t = 0; t < 60; t++) begin
      adv();
      chk();
      if (done) begin
        td = t; seen = 1;
      end else if (seen && gnt != 0 && prev == 0) begin
        rg = t;
        check("regrant_port", 32'(oh_idx(gnt)), 32'd3);
        break;
      end
      prev = gnt;
    end
    check("regrant_gap", 32'(rg - td - 1), 32'(GP + 1));

    // Randomized traffic against the reference model
    do_reset();
    for (int t = 0; t < 2000; t++) begin
      adv();
      for (int p = 0; p < N; p++) req[p] = ($urandom_range(0, 3) == 0);
      req_rw    = N'($urandom);
      req_addr  = (N*AB)'($urandom);
      req_frame = (N*FB)'($urandom);
      req_wdata = $urandom;
      mmu_rdata = DB'($urandom);
      chk();
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
